// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for alu_share_arbiter: two request channels, the shared-ALU port and
// the tagged response channel. slave = arbiter side, master = clients/ALU/consumer side.
interface alu_share_arbiter_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [1:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [1:0]       req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_y;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_id;
    logic             rsp_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_y,
        output rsp_valid, rsp_y, rsp_id, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_y,
        input  rsp_valid, rsp_y, rsp_id, rsp_zero,
        output rsp_ready
    );

endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two clients: arbitrate, issue, capture, respond.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus_io
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic             prefer0;
    logic             gnt0;
    logic             gnt1;
    logic             accept;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // High when client 1 held the last grant, so client 0 wins the next contest.
    logic last_q, last_d;

    assign prefer0 = last_q;
    assign last_d  = accept ? gnt1 : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign prefer0 = 1'b1;
`endif

    // Grants are held off while reset is asserted, even though the state reads idle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle && rst_n) begin
            gnt0 = bus_io.req0_valid & (prefer0 | ~bus_io.req1_valid);
            gnt1 = bus_io.req1_valid & ~gnt0;
        end
    end

    assign accept = gnt0 | gnt1;

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        id_d       = id_q;
        rsp_y_d    = rsp_y_q;
        rsp_zero_d = rsp_zero_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    alu_a_d  = gnt1 ? bus_io.req1_a  : bus_io.req0_a;
                    alu_b_d  = gnt1 ? bus_io.req1_b  : bus_io.req0_b;
                    alu_op_d = gnt1 ? bus_io.req1_op : bus_io.req0_op;
                    id_d     = gnt1;
                    state_d  = StExec;
                end
            end
            StExec: begin
                rsp_y_d    = bus_io.alu_y;
                rsp_zero_d = (bus_io.alu_y == '0);
                state_d    = StResp;
            end
            StResp: begin
                if (bus_io.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= 2'b00;
            id_q       <= 1'b0;
            rsp_y_q    <= '0;
            rsp_zero_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            id_q       <= id_d;
            rsp_y_q    <= rsp_y_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign bus_io.req0_ready = gnt0;
    assign bus_io.req1_ready = gnt1;
    assign bus_io.alu_a      = alu_a_q;
    assign bus_io.alu_b      = alu_b_q;
    assign bus_io.alu_op     = alu_op_q;
    // Decoded from state so an asynchronous reset drops it immediately.
    assign bus_io.rsp_valid  = (state_q == StResp);
    assign bus_io.rsp_y      = rsp_y_q;
    assign bus_io.rsp_id     = id_q;
    assign bus_io.rsp_zero   = rsp_zero_q;

endmodule
